log_event_arb: RTL

LOG_EVENT_ARB -- requirements
Module: log_event_arb

---
 rtl/log_event_arb_if.sv | 37 +++
 rtl/log_event_arb.sv | 137 +++++++++++++
 2 files changed

// File: rtl/log_event_arb_if.sv
// Bus bundle for log_event_arb: event sources, host clear control and logger side.
//
// Handshake: a source raises Req_SI[i] with its Data_DI slice stable and keeps
// both unchanged until it sees Ack_SO[i] high in the same cycle; the event is
// consumed at the clock edge where Req_SI[i] & Ack_SO[i]. Ack_SO is a
// combinational acceptance and is one-hot or zero. On the logger side
// LogTrigger_SO and LogClear_SO are single-cycle strobes; LogReady_SI is the
// logger's status and is sampled, never acknowledged.
interface log_event_arb_if #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_DATA_BITW = 24,
  parameter int LOG_DATA_BITW = 32
);
  logic [NUM_SRC-1:0]               Req_SI;
  logic [NUM_SRC*SRC_DATA_BITW-1:0] Data_DI;
  logic [NUM_SRC-1:0]               Ack_SO;
  logic                             En_SI;
  logic                             Clear_SI;
  logic                             LogReady_SI;
  logic [LOG_DATA_BITW-1:0]         LogData_DO;
  logic                             LogTrigger_SO;
  logic                             LogClear_SO;
  logic                             Busy_SO;
  logic [15:0]                      DropCnt_DO;

  // Environment side: sources, host and logger status.
  modport master (
    output Req_SI, Data_DI, En_SI, Clear_SI, LogReady_SI,
    input  Ack_SO, LogData_DO, LogTrigger_SO, LogClear_SO, Busy_SO, DropCnt_DO
  );

  // Arbiter side.
  modport slave (
    input  Req_SI, Data_DI, En_SI, Clear_SI, LogReady_SI,
    output Ack_SO, LogData_DO, LogTrigger_SO, LogClear_SO, Busy_SO, DropCnt_DO
  );
endinterface

// File: rtl/log_event_arb.sv
// Round-robin arbiter that funnels per-source events into a single logger,
// with a drop-or-stall policy when the logger is not ready and a host-driven
// clear sequence (drain, clear strobe, wait for logger ready).
module log_event_arb #(
  parameter int NUM_SRC       = 4,
  parameter int SRC_DATA_BITW = 24,
  parameter int LOG_DATA_BITW = 32,
  parameter int DROP_ON_FULL  = 1
) (
  input  logic        Clk_CI,
  input  logic        Rst_RBI,
  log_event_arb_if.slave bus,
  output logic [1:0]  DbgState_DO
);

  localparam int PTR_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    CLR_DRAIN = 2'd1,
    CLR_ISSUE = 2'd2,
    CLR_WAIT  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic                     trig_q, trig_d;
  logic [LOG_DATA_BITW-1:0] data_q, data_d;
  logic [15:0]              drop_q, drop_d;

  logic                     eligible;
  logic                     grant_found;
  logic [PTR_W-1:0]         grant_idx;
  logic                     grant;
  logic [NUM_SRC-1:0]       ack;
  logic                     busy;
  logic                     log_clear;

  // Eligibility: only in RUN, enabled, no clear pending, and the logger can
  // either take the event or we are allowed to drop it. Reset forces it low so
  // no Ack leaks out while the block is held in reset.
  assign eligible = Rst_RBI && (state_q == RUN) && bus.En_SI && !bus.Clear_SI &&
                    (bus.LogReady_SI || (DROP_ON_FULL != 0));

  // Cyclic scan starting just after the last granted source.
  always_comb begin
    int               idx;
    logic [PTR_W-1:0] idx_w;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    idx_w       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_SRC) idx = idx - NUM_SRC;
      idx_w = PTR_W'(idx);
      if (!grant_found && bus.Req_SI[idx_w]) begin
        grant_found = 1'b1;
        grant_idx   = idx_w;
      end
    end
  end

  assign grant = eligible && grant_found;

  // FSM state register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) state_q <= RUN;
    else          state_q <= state_d;
  end

  // FSM next state: clear is accepted only in RUN, then drain, issue, wait.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:       if (bus.Clear_SI) state_d = CLR_DRAIN;
      CLR_DRAIN: state_d = CLR_ISSUE;
      CLR_ISSUE: state_d = CLR_WAIT;
      CLR_WAIT:  if (bus.LogReady_SI) state_d = RUN;
      default:   state_d = RUN;
    endcase
  end

  // FSM outputs: grant one-hot, busy flag, clear strobe and debug state.
  always_comb begin
    ack = '0;
    if (grant) ack[grant_idx] = 1'b1;
    busy        = Rst_RBI && (state_q != RUN);
    log_clear   = (state_q == CLR_ISSUE);
    DbgState_DO = state_q;
  end

  // Datapath next values: pointer, trigger/data capture, drop counter.
  always_comb begin
    ptr_d  = ptr_q;
    trig_d = 1'b0;
    data_d = data_q;
    drop_d = drop_q;
    if (grant) begin
      ptr_d = grant_idx;
      if (bus.LogReady_SI) begin
        trig_d = 1'b1;
        data_d = '0;
        data_d[7:0] = 8'(grant_idx);
        data_d[8 +: SRC_DATA_BITW] =
          bus.Data_DI[grant_idx*SRC_DATA_BITW +: SRC_DATA_BITW];
      end else if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
    end
    // Leaving the clear sequence resets the drop statistics.
    if (state_q == CLR_WAIT && bus.LogReady_SI) drop_d = '0;
  end

  // Datapath registers; pointer resets to the last source so source 0 wins first.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      ptr_q  <= PTR_W'(NUM_SRC - 1);
      trig_q <= 1'b0;
      data_q <= '0;
      drop_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      trig_q <= trig_d;
      data_q <= data_d;
      drop_q <= drop_d;
    end
  end

  assign bus.Ack_SO        = ack;
  assign bus.Busy_SO       = busy;
  assign bus.LogClear_SO   = log_clear;
  assign bus.LogTrigger_SO = trig_q;
  assign bus.LogData_DO    = data_q;
  assign bus.DropCnt_DO    = drop_q;

endmodule
